// File: rtl/data_mem_responder_if.sv
// ---------------------------------------------------------------------------
// data_mem_responder_if
//   Groups the load/store request channel and the response channel that run
//   between the CPU datapath (master) and the latency-inserting data memory
//   (slave).
//
//   Request channel (master -> slave, except req_ready):
//     req_valid  request present
//     req_ready  responder can accept a request
//     req_write  1 = store, 0 = load
//     req_addr   byte address, ADDR_W bits
//     req_wdata  store data
//     req_be     byte enables for stores
//   Response channel (slave -> master, except rsp_ready):
//     rsp_valid  response present
//     rsp_ready  datapath accepts the response
//     rsp_rdata  load data (0 for stores and errors)
//     rsp_err    misaligned or out-of-range access
// ---------------------------------------------------------------------------
interface data_mem_responder_if #(
  parameter int ADDR_W = 16
);

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [3:0]        req_be;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
//   Memory-side responder for the datapath load/store port. Accepts one
//   request at a time, waits WAIT_CYCLES extra cycles, performs a byte-enabled
//   word store or a word load on an internal DEPTH_WORDS x 32 array, and then
//   presents the result until the datapath takes it.
//
//   Ports:
//     clk_i   rising-edge clock
//     rst_ni  asynchronous active-low reset (memory contents are kept)
//     bus     data_mem_responder_if slave modport (request + response)
//
//   Parameters:
//     ADDR_W       byte-address width
//     DEPTH_WORDS  number of 32-bit words; legal word index 0..DEPTH_WORDS-1
//     WAIT_CYCLES  wait states between accept and response, 0..15
// ---------------------------------------------------------------------------
module data_mem_responder #(
  parameter int ADDR_W      = 16,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  data_mem_responder_if.slave bus
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                ready_q, ready_d;
  logic                write_q, write_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [3:0]          be_q, be_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                err_q, err_d;

  logic                access;
  logic                addr_err;
  logic [ADDR_W-3:0]   word_idx;
  logic [IDX_W-1:0]    mem_idx;

  logic [31:0]         mem [DEPTH_WORDS];

  // Address decode works on the latched request. The range check compares the
  // full word index so addresses beyond the array never alias onto low words.
  assign word_idx = addr_q[ADDR_W-1:2];
  assign mem_idx  = word_idx[IDX_W-1:0];
  assign addr_err = (addr_q[1:0] != 2'b00) || (32'(word_idx) >= 32'(DEPTH_WORDS));

  // req_ready is registered so it stays low while reset is asserted and only
  // rises on the first edge after release (and one cycle after a response).
  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

  // Next-state logic. The counter is loaded on accept and counts down in
  // S_WAIT; the access happens on the edge where it is already zero, so
  // S_WAIT always lasts WAIT_CYCLES+1 cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    access  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid && ready_q) begin
          write_d = bus.req_write;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          be_d    = bus.req_be;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          access  = 1'b1;
          state_d = S_RESP;
          err_d   = addr_err;
          rdata_d = (!addr_err && !write_q) ? mem[mem_idx] : 32'h0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    ready_d = (state_d == S_IDLE);
  end

  // Control and response registers; reset drops any in-flight request.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      ready_q <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      be_q    <= 4'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage array is deliberately outside the reset domain. A reset while in
  // S_WAIT forces state_q to S_IDLE immediately, so access can never fire for
  // a dropped request.
  always_ff @(posedge clk_i) begin
    if (access && write_q && !addr_err) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) begin
          mem[mem_idx][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_data_mem_responder
//   Self-checking bench for data_mem_responder. Requests push their expected
//   response (from a word-array reference model) onto a queue; each response
//   popped from the DUT is compared against the head of that queue.
// ---------------------------------------------------------------------------
module tb_data_mem_responder;

  localparam int ADDR_W      = 16;
  localparam int DEPTH_WORDS = 1024;
  localparam int WAIT_CYCLES = 2;
  localparam int LATENCY     = WAIT_CYCLES + 1;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  data_mem_responder_if #(.ADDR_W(ADDR_W)) bus ();

  data_mem_responder #(
    .ADDR_W      (ADDR_W),
    .DEPTH_WORDS (DEPTH_WORDS),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model [DEPTH_WORDS];
  exp_t        exp_q [$];

  logic [31:0] got_rdata;
  logic        got_err;
  int          got_lat;
  bit          got_ok;

  // Drives one request, updates the reference model and queues the expected
  // response when track is set. Returns one time unit after the accept edge.
  task automatic send_request(input logic w, input logic [15:0] a,
                              input logic [31:0] d, input logic [3:0] be,
                              input bit track);
    exp_t e;
    logic aerr;
    int   idx;
    int   n;
    idx     = int'(a[15:2]);
    aerr    = (a[1:0] != 2'b00) || (idx >= DEPTH_WORDS);
    e.err   = aerr;
    e.rdata = 32'h0;
    if (track && !aerr) begin
      if (w) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) model[idx][8*i +: 8] = d[8*i +: 8];
        end
      end else begin
        e.rdata = model[idx];
      end
    end
    if (track) exp_q.push_back(e);
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_be    = be;
    bus.req_valid = 1'b1;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: req_ready=%b after %0d cycles, required 1", bus.req_ready, n);
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  // Waits (bounded) for rsp_valid, captures the response and latency, then
  // completes the response handshake.
  task automatic get_response();
    got_lat = 0;
    while (bus.rsp_valid !== 1'b1 && got_lat < 50) begin
      @(posedge clk); #1;
      got_lat++;
    end
    got_ok    = (bus.rsp_valid === 1'b1);
    got_rdata = bus.rsp_rdata;
    got_err   = bus.rsp_err;
    if (got_ok) begin
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bus.rsp_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = 32'h0;
    bus.req_be    = 4'h0;
    bus.rsp_ready = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.req_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_req_ready: got %b, expected 0", bus.req_ready);
    end
    checks++;
    if (bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_rsp_valid: got %b, expected 0", bus.rsp_valid);
    end
    checks++;
    if (bus.rsp_rdata !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_rsp_rdata: got %h, expected 0", bus.rsp_rdata);
    end
    checks++;
    if (bus.rsp_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_rsp_err: got %b, expected 0", bus.rsp_err);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_exit_req_ready: got %b, expected 1", bus.req_ready);
    end
  endtask

  task automatic test_store_load();
    exp_t e;
    logic        w [2]  = '{1'b1, 1'b0};
    logic [31:0] d [2]  = '{32'hDEADBEEF, 32'h0};
    for (int t = 0; t < 2; t++) begin
      send_request(w[t], 16'h0010, d[t], 4'hF, 1'b1);
      get_response();
      e = exp_q.pop_front();
      checks++;
      if (!got_ok || got_rdata !== e.rdata || got_err !== e.err || got_lat != LATENCY) begin
        errors++;
        $display("[TB] FAIL store_load[%0d]: valid=%b rdata=%h err=%b lat=%0d, expected rdata=%h err=%b lat=%0d",
                 t, got_ok, got_rdata, got_err, got_lat, e.rdata, e.err, LATENCY);
      end
    end
    checks++;
    if (got_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("[TB] FAIL store_load_value: got %h, expected deadbeef", got_rdata);
    end
  endtask

  task automatic test_byte_enable();
    exp_t e;
    logic        w  [4] = '{1'b1,        1'b0, 1'b1,        1'b1};
    logic [31:0] d  [4] = '{32'h000000AA, 32'h0, 32'hFFFFFFFF, 32'h11223344};
    logic [3:0]  be [4] = '{4'b0001,     4'h0, 4'b0000,     4'b1010};
    for (int t = 0; t < 4; t++) begin
      send_request(w[t], 16'h0010, d[t], be[t], 1'b1);
      get_response();
      e = exp_q.pop_front();
      checks++;
      if (!got_ok || got_rdata !== e.rdata || got_err !== e.err || got_lat != LATENCY) begin
        errors++;
        $display("[TB] FAIL byte_enable[%0d]: valid=%b rdata=%h err=%b lat=%0d, expected rdata=%h err=%b lat=%0d",
                 t, got_ok, got_rdata, got_err, got_lat, e.rdata, e.err, LATENCY);
      end
      if (t == 1) begin
        checks++;
        if (got_rdata !== 32'hDEADBEAA) begin
          errors++;
          $display("[TB] FAIL byte_enable_value: got %h, expected deadbeaa", got_rdata);
        end
      end
    end
    send_request(1'b0, 16'h0010, 32'h0, 4'hF, 1'b1);
    get_response();
    e = exp_q.pop_front();
    checks++;
    if (!got_ok || got_rdata !== 32'h11AD33AA || got_rdata !== e.rdata) begin
      errors++;
      $display("[TB] FAIL byte_enable_partial: got %h, expected 11ad33aa", got_rdata);
    end
  endtask

  task automatic test_errors();
    exp_t e;
    logic        w  [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [15:0] a  [8] = '{16'h0012, 16'h1000, 16'h0011, 16'h1000,
                            16'hFFFC, 16'h0010, 16'h0FFC, 16'h0FFC};
    logic [31:0] d  [8] = '{32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF,
                            32'hFFFFFFFF, 32'h0, 32'h0BADC0DE, 32'h0};
    for (int t = 0; t < 8; t++) begin
      send_request(w[t], a[t], d[t], 4'hF, 1'b1);
      get_response();
      e = exp_q.pop_front();
      checks++;
      if (!got_ok || got_rdata !== e.rdata || got_err !== e.err || got_lat != LATENCY) begin
        errors++;
        $display("[TB] FAIL errors[%0d] addr=%h: valid=%b rdata=%h err=%b lat=%0d, expected rdata=%h err=%b lat=%0d",
                 t, a[t], got_ok, got_rdata, got_err, got_lat, e.rdata, e.err, LATENCY);
      end
    end
  endtask

  task automatic test_stall();
    exp_t        e;
    logic [31:0] held;
    int          n;
    send_request(1'b0, 16'h0010, 32'h0, 4'hF, 1'b1);
    n = 0;
    while (bus.rsp_valid !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    held = bus.rsp_rdata;
    e = exp_q.pop_front();
    checks++;
    if (bus.rsp_valid !== 1'b1 || held !== e.rdata || bus.rsp_err !== e.err) begin
      errors++;
      $display("[TB] FAIL stall_response: valid=%b rdata=%h err=%b, expected valid=1 rdata=%h err=%b",
               bus.rsp_valid, held, bus.rsp_err, e.rdata, e.err);
    end
    bus.req_write = 1'b1;
    bus.req_addr  = 16'h0010;
    bus.req_wdata = 32'hFFFFFFFF;
    bus.req_be    = 4'hF;
    bus.req_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== held || bus.req_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL stall_hold[%0d]: valid=%b rdata=%h req_ready=%b, expected valid=1 rdata=%h req_ready=0",
                 c, bus.rsp_valid, bus.rsp_rdata, bus.req_ready, held);
      end
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL stall_release: valid=%b req_ready=%b, expected valid=0 req_ready=1",
               bus.rsp_valid, bus.req_ready);
    end
    // The store offered during the stall must not have reached memory.
    send_request(1'b0, 16'h0010, 32'h0, 4'hF, 1'b1);
    get_response();
    e = exp_q.pop_front();
    checks++;
    if (!got_ok || got_rdata !== e.rdata || got_err !== e.err) begin
      errors++;
      $display("[TB] FAIL stall_ignored_store: rdata=%h err=%b, expected rdata=%h err=%b",
               got_rdata, got_err, e.rdata, e.err);
    end
  endtask

  task automatic test_reset_mid_wait();
    exp_t e;
    send_request(1'b1, 16'h0020, 32'hCAFEF00D, 4'hF, 1'b1);
    get_response();
    e = exp_q.pop_front();
    checks++;
    if (!got_ok || got_err !== e.err) begin
      errors++;
      $display("[TB] FAIL midreset_prestore: valid=%b err=%b, expected valid=1 err=%b", got_ok, got_err, e.err);
    end
    send_request(1'b1, 16'h0020, 32'h12345678, 4'hF, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    checks++;
    if (bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_rsp_valid: got %b, expected 0", bus.rsp_valid);
    end
    @(posedge clk); #1;
    send_request(1'b0, 16'h0020, 32'h0, 4'hF, 1'b1);
    get_response();
    e = exp_q.pop_front();
    checks++;
    if (!got_ok || got_rdata !== 32'hCAFEF00D || got_rdata !== e.rdata || got_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_old_value: rdata=%h err=%b, expected rdata=cafef00d err=0", got_rdata, got_err);
    end
  endtask

  task automatic test_back_to_back();
    exp_t        e;
    logic [15:0] a;
    logic        w;
    for (int k = 0; k < 6; k++) begin
      send_request(1'b1, 16'h0100 + 16'(4 * k), $urandom, 4'hF, 1'b1);
      get_response();
      e = exp_q.pop_front();
      checks++;
      if (!got_ok || got_rdata !== e.rdata || got_err !== e.err || got_lat != LATENCY) begin
        errors++;
        $display("[TB] FAIL b2b_fill[%0d]: rdata=%h err=%b lat=%0d, expected rdata=%h err=%b lat=%0d",
                 k, got_rdata, got_err, got_lat, e.rdata, e.err, LATENCY);
      end
    end
    for (int k = 0; k < 12; k++) begin
      a = 16'h0100 + 16'(4 * $urandom_range(0, 5));
      w = 1'($urandom_range(0, 1));
      send_request(w, a, $urandom, 4'($urandom_range(0, 15)), 1'b1);
      get_response();
      e = exp_q.pop_front();
      checks++;
      if (!got_ok || got_rdata !== e.rdata || got_err !== e.err || got_lat != LATENCY ||
          bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL b2b[%0d] w=%b addr=%h: rdata=%h err=%b lat=%0d req_ready=%b, expected rdata=%h err=%b lat=%0d req_ready=1",
                 k, w, a, got_rdata, got_err, got_lat, bus.req_ready, e.rdata, e.err, LATENCY);
      end
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_byte_enable();
    test_errors();
    test_stall();
    test_reset_mid_wait();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
